// File: rtl/decision_pkg.sv
// Shared types and constants for the decision packer: arm encoding of the
// upstream priority select and the default hit-counter width.
package decision_pkg;

    // Arm of the nested priority select that produced a decision bit.
    typedef enum logic [1:0] {
        RULE_B       = 2'd0,
        RULE_CD      = 2'd1,
        RULE_EF      = 2'd2,
        RULE_DEFAULT = 2'd3
    } rule_e;

    localparam int NUM_RULES     = 4;
    localparam int HIT_W_DEFAULT = 16;

endpackage

// File: rtl/decision_fifo.sv
// Small in-order synchronous FIFO holding packed words together with their
// bit counts. The flags come straight from the registered occupancy count, so
// nothing on the read side feeds the full flag combinationally.
module decision_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // An empty FIFO presents zero so the output is clean after reset and drain.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, cleared on reset so no stale word survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/decision_packer.sv
// Packs decision bits from the nested priority select LSB-first into W-bit
// words, hands them out over valid/ready through a small FIFO, supports
// flushing partial words, and keeps saturating per-arm hit counters.
module decision_packer
    import decision_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int HIT_W = HIT_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic [1:0]                 in_rule,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(W+1)-1:0]     out_count,
    output logic [NUM_RULES*HIT_W-1:0] hit_cnt
);

    localparam int CW = $clog2(W + 1);
    localparam int FW = CW + W;

    logic [W-1:0]     acc;
    logic [W-1:0]     acc_next;
    logic [CW-1:0]    acc_cnt;
    logic [CW-1:0]    cnt_next;
    logic             flush_pend;
    logic             flush_req;
    logic             flush_svc;
    logic             accept;
    logic             word_done;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_rdata;
    logic [HIT_W-1:0] hits [NUM_RULES];
    rule_e            rule;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
        return (&v) ? v : v + HIT_W'(1);
    endfunction

    assign rule      = rule_e'(in_rule);
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign flush_req = flush || flush_pend;
    // A flush can only complete when its word (if any) has somewhere to go.
    assign flush_svc = flush_req && !fifo_full;

    // Fold the incoming bit into the accumulator and decide whether a word
    // leaves this cycle; an accept that also completes a flush pushes once.
    always_comb begin
        acc_next = acc;
        cnt_next = acc_cnt;
        if (accept) begin
            for (int i = 0; i < W; i++) begin
                if (acc_cnt == CW'(i)) acc_next[i] = in_bit;
            end
            cnt_next = acc_cnt + CW'(1);
        end
        word_done = accept && (cnt_next == CW'(W));
        push      = word_done || (flush_svc && (cnt_next != '0));
    end

    // Accumulator state: cleared whenever its contents are pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (push) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            acc     <= acc_next;
            acc_cnt <= cnt_next;
        end
    end

    // Remember a flush request until the FIFO can take the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (flush_svc) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    // Per-arm hit counters, bumped on every accepted decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_RULES; k++) hits[k] <= '0;
        end else if (accept) begin
            hits[rule] <= sat_inc(hits[rule]);
        end
    end

    for (genvar k = 0; k < NUM_RULES; k++) begin : g_hit_flat
        assign hit_cnt[k*HIT_W +: HIT_W] = hits[k];
    end

    decision_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cnt_next, acc_next}),
        .pop       (out_ready),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid            = !fifo_empty;
    assign {out_count, out_data} = fifo_rdata;

endmodule

// File: tb/tb_decision_packer.sv
// Directed self-checking bench for decision_packer (W=8, DEPTH=2, HIT_W=16).
module tb_decision_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic [1:0]  in_rule;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_count;
    logic [63:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    decision_packer #(.W(8), .DEPTH(2), .HIT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_rule   (in_rule),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  pat1;
        logic [7:0]  pat6;
        logic [23:0] pat3;
        logic [7:0]  exp_w [3];
        int          idx;
        int          got;
        int          n_acc;

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_rule = 2'd0;
        flush = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_count", out_count, 0);
        check("rst_hit_cnt",   hit_cnt,   0);
        tick();
        rst = 1'b0;

        // Full word: bits 1,0,1,1,0,0,1,0 -> 8'h4D, visible only after the 8th accept.
        pat1 = 8'h4D;
        in_valid = 1'b1; in_rule = 2'd3; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_bit = pat1[i];
            tick();
            if (i < 7) check("t1_no_early_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        check("t1_valid", out_valid, 1);
        check("t1_data",  out_data,  8'h4D);
        check("t1_count", out_count, 8);
        check("t1_hit3",  hit_cnt[63:48], 8);
        tick();
        check("t1_valid_one_cycle", out_valid, 0);

        // Partial word via flush: bits 1,1,0 -> 8'h03, count 3.
        in_rule = 2'd0; in_valid = 1'b1;
        in_bit = 1'b1; tick();
        in_bit = 1'b1; tick();
        in_bit = 1'b0; tick();
        in_valid = 1'b0;
        check("t2_no_valid_before_flush", out_valid, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_valid", out_valid, 1);
        check("t2_data",  out_data,  8'h03);
        check("t2_count", out_count, 3);
        check("t2_hit0",  hit_cnt[15:0], 3);
        tick();
        check("t2_popped", out_valid, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_empty_flush_a", out_valid, 0);
        tick();
        check("t2_empty_flush_b", out_valid, 0);

        // Back-pressure: 24 bits with the consumer stalled, then drained.
        pat3 = 24'hA5C33C;
        exp_w[0] = 8'h3C; exp_w[1] = 8'hC3; exp_w[2] = 8'hA5;
        out_ready = 1'b0; in_rule = 2'd1; in_valid = 1'b1; idx = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            in_bit = pat3[idx];
            if (in_ready) idx++;
            tick();
        end
        check("t3_accepted_16", idx, 16);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_valid",  out_valid, 1);
        check("t3_head",   out_data,  8'h3C);
        in_bit = pat3[16];
        for (int c = 0; c < 3; c++) begin
            if (in_ready) idx++;
            tick();
        end
        check("t3_stall_no_accept", idx, 16);
        check("t3_stall_in_ready", in_ready, 0);
        check("t3_stall_head_stable", out_data, 8'h3C);
        check("t3_stall_count_stable", out_count, 8);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 60 && (idx < 24 || got < 3); c++) begin
            in_valid = (idx < 24);
            in_bit   = (idx < 24) ? pat3[idx] : 1'b0;
            if (out_valid && got < 3) begin
                check("t3_word",  out_data,  exp_w[got]);
                check("t3_wcount", out_count, 8);
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        check("t3_words_drained", got, 3);
        check("t3_bits_accepted", idx, 24);
        check("t3_in_ready_back", in_ready, 1);
        check("t3_fifo_empty", out_valid, 0);
        check("t3_hit1", hit_cnt[31:16], 24);

        // Accept plus flush on the 8th bit: exactly one word of 8 bits.
        in_rule = 2'd3; in_valid = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        in_bit = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_valid", out_valid, 1);
        check("t4_data",  out_data,  8'h7F);
        check("t4_count", out_count, 8);
        tick();
        check("t4_single_word_a", out_valid, 0);
        tick();
        check("t4_single_word_b", out_valid, 0);
        check("t4_hit3", hit_cnt[63:48], 16);

        // Saturation: 70000 accepts on arm 2 after a clean reset.
        rst = 1'b1; #2; rst = 1'b0;
        check("t5_hit_cleared", hit_cnt, 0);
        in_rule = 2'd2; in_valid = 1'b1; out_ready = 1'b1; n_acc = 0;
        for (int c = 0; c < 70000; c++) begin
            in_bit = c[0];
            if (in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        check("t5_all_accepted", n_acc, 70000);
        check("t5_hit_sat", hit_cnt, {16'h0, 16'hFFFF, 32'h0});
        tick();
        check("t5_drained", out_valid, 0);

        // Asynchronous reset mid-word with a word waiting in the FIFO.
        out_ready = 1'b0; in_rule = 2'd0; in_valid = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        in_valid = 1'b0;
        check("t6_word_waiting", out_valid, 1);
        #2; rst = 1'b1; #1;
        check("t6_rst_in_ready",  in_ready,  1);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data",  out_data,  0);
        check("t6_rst_out_count", out_count, 0);
        check("t6_rst_hit_cnt",   hit_cnt,   0);
        tick();
        rst = 1'b0;
        pat6 = 8'h96; out_ready = 1'b1; in_valid = 1'b1; in_rule = 2'd1;
        for (int i = 0; i < 8; i++) begin
            in_bit = pat6[i];
            tick();
            if (i < 7) check("t6_acc_cleared", out_valid, 0);
        end
        in_valid = 1'b0;
        check("t6_valid", out_valid, 1);
        check("t6_data",  out_data,  8'h96);
        check("t6_count", out_count, 8);
        check("t6_hit1",  hit_cnt, {32'h0, 16'd8, 16'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decision_packer.md
# decision_packer

Downstream consumer of the nested priority-select stage. That stage produces one decision bit per cycle: 1 when `b`, 0 when `c&d`, 1 when `e&f`, otherwise 0. This block accepts each decision bit with the index of the arm that produced it. It packs the bits LSB-first into W-bit words and hands the words out over a valid/ready interface through a small FIFO. It also keeps saturating per-arm hit counters for debug readout.

## Interface
Parameters:
- `W`, 8: bits per packed output word (≥2)
- `DEPTH`, 2: output FIFO entries (power of two, ≥2)
- `HIT_W`, 16: width of each per-arm hit counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decision bit present
- `in_bit`  in  1  decision value from the priority select
- `in_rule`  in  2  arm taken: 0 = `b`, 1 = `c&d`, 2 = `e&f`, 3 = default
- `in_ready`  out  1  block accepts a decision this cycle
- `flush`  in  1  single-cycle request to emit a partial word
- `out_valid`  out  1  word available
- `out_ready`  in  1  consumer takes word
- `out_data`  out  W  packed bits; bit 0 is the oldest
- `out_count`  out  $clog2(W+1)  number of meaningful bits in `out_data` (1..W)
- `hit_cnt`  out  4×HIT_W  per-arm counters; arm k occupies bits [k*HIT_W +: HIT_W]

## Operation
- Accumulator: `acc` (W bits) plus `acc_cnt` (0..W-1).
- Accept: accept occurs when `in_valid && in_ready`.
  - `in_bit` is written to `acc[acc_cnt]` and `acc_cnt` increments.
  - `hit_cnt[in_rule]` increments, saturating at all-ones and never wrapping.
- Push: a word is pushed to the FIFO when an accept makes the count reach W, or when a flush is serviced with ≥1 bit held.
  - Pushed word = `acc` including the bit accepted this cycle; unused upper bits are 0.
  - `out_count` = number of held bits.
  - `acc` and `acc_cnt` clear on push.
- Flush:
  - `flush` sets a `flush_pend` register.
  - The flush is serviced on the first cycle with `flush_pend` (or `flush`) set and the FIFO not full. It then clears.
  - Flush with 0 bits held: cleared, no push.
  - Accept and flush in the same cycle: the bit is accepted first, then the word is pushed including that bit. If that bit completes W, exactly one word is pushed.
- Back-pressure:
  - `in_ready` = !`fifo_full`, taken from registered FIFO state only, with no combinational path from `out_ready`.
  - A pop while full frees space visible on the next cycle.
- FIFO: in-order, `DEPTH` entries, simultaneous push and pop permitted when not full and not empty.
- Reset, including mid-word or mid-flush:
  - `acc`, `acc_cnt`, `flush_pend`, FIFO contents and `hit_cnt` are all zeroed.
  - Output reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `hit_cnt`=0.

## Timing
- Latency: a push at edge t gives `out_valid`=1 after that edge, so the word is visible in the cycle following the completing accept or the flush service.
- `out_data` and `out_count` are held stable while `out_valid && !out_ready`.
- Throughput: one bit per cycle sustained when the consumer keeps `out_ready` high.
- Counters update at the edge of the accept and are readable in the next cycle.

## Structure
- Package `decision_pkg`:
  - `rule_e` enum (`RULE_B`, `RULE_CD`, `RULE_EF`, `RULE_DEFAULT`)
  - `NUM_RULES`=4
  - default `HIT_W`
- Sub-module `decision_fifo`: parameterised `WIDTH`/`DEPTH` synchronous FIFO with `full` and `empty` flags, asynchronous active-high reset on `rst`. Holds `{out_count, out_data}`.
- Top level holds the accumulator, flush logic and hit counters.

## Test plan
- W=8, 8 accepts with bits 1,0,1,1,0,0,1,0 and `out_ready`=1 → one word `out_data`=8'h4D, `out_count`=8, `out_valid` for exactly 1 cycle, the cycle after the 8th accept.
- 3 accepts (bits 1,1,0) then `flush` → `out_data`=8'h03, `out_count`=3. A second `flush` with an empty accumulator → no word.
- `out_ready`=0, stream 24 bits with DEPTH=2:
  - `in_ready` falls in the cycle after the 2nd word push.
  - Raising `out_ready` drains words in order and `in_ready` returns.
  - No bit is lost or duplicated.
- Accept and `flush` in the same cycle on the 8th bit → exactly one word with `out_count`=8.
- 70000 accepts with `in_rule`=2 → `hit_cnt` arm 2 = 16'hFFFF, other arms = 0. Assert `rst` mid-word → all outputs return to their reset values asynchronously.
